// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs KGP_RISC fields into canonical words and streams them into instruction memory.
// Build option: define INST_FIELD_CHECK_EN to add the sticky field_err output.
module inst_encode_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [3:0]        func,
    input  logic [15:0]       offset,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic [ADDR_W:0]   count,
    output logic              done,
`ifdef INST_FIELD_CHECK_EN
    output logic              field_err,
`endif
    output logic              overflow
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCEPT = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              keep_rs, keep_off, use_rt, use_shamt;
    logic [31:0]       word_c;
    logic              at_end;

    // Field usage per instruction class; anything unused is forced to zero in the word
    always_comb begin
        use_shamt = (opcode == 2'b00) && func[3];
        use_rt    = (opcode != 2'b11) ? !use_shamt : func[3];
        keep_rs   = !((opcode == 2'b11) && (func[3:2] == 2'b00));
        keep_off  = (opcode == 2'b00) ? (func[2:1] == 2'b10) : !((opcode == 2'b11) && (func[3:1] == 3'b001));
        word_c    = {opcode, keep_rs ? rs : 5'd0, use_shamt ? shamt : (use_rt ? rt : 5'd0), func, keep_off ? offset : 16'd0};
    end

    assign at_end     = (addr_q == LAST_A);
    assign in_ready   = (state_q == ACCEPT);
    assign imem_we    = (state_q == WRITE);
    assign done       = (state_q == DONE);
    assign imem_addr  = addr_q;
    assign imem_wdata = data_q;
    assign count      = cnt_q;
    assign overflow   = ovf_q;

    // Session sequencing: accept a bundle, hold the write until acknowledged, repeat
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = ACCEPT;
                addr_d  = BASE_A;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
            ACCEPT: if (in_valid) begin
                state_d = WRITE;
                data_d  = word_c;
                last_d  = in_last;
            end
            WRITE: if (imem_ready) begin
                cnt_d   = cnt_q + 1'b1;
                addr_d  = at_end ? addr_q : addr_q + 1'b1;
                ovf_d   = ovf_q | (!last_q && at_end);
                state_d = (last_q || at_end) ? DONE : ACCEPT;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= BASE_A;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef INST_FIELD_CHECK_EN
    logic ferr_q, err_c;
    assign err_c     = (!keep_rs && (rs != 5'd0)) || (!use_rt && (rt != 5'd0)) ||
                       (!use_shamt && (shamt != 5'd0)) || (!keep_off && (offset != 16'd0));
    assign field_err = ferr_q;

    // Sticky per session: cleared by an honoured start, set by any accepted non-canonical bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ferr_q <= 1'b0;
        else if (state_q == IDLE && start) ferr_q <= 1'b0;
        else if (state_q == ACCEPT && in_valid && err_c) ferr_q <= 1'b1;
    end
`endif
endmodule

// File: doc/inst_encode_loader.md
Name: inst_encode_loader

Overview:
Packs decoded instruction fields (opcode, rs, rt, shamt, func, offset) into canonical 32-bit KGP_RISC instruction words. Writes each word into instruction memory at consecutive addresses from a base address. Sits between the testbench or boot loader and instruction memory, and is the inverse of the instruction decoder. Field input uses a valid/ready handshake; each memory write is held until the memory acknowledges it.

Parameters:
ADDR_W, 10, instruction memory address width
DEPTH, 1024, number of instruction memory words; must be ≤ 2^ADDR_W
BASE_ADDR, 0, first write address after start

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse that begins a load session; honoured only in IDLE
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a field bundle
in_last  input  1  marks the final instruction of the session
opcode  input  2  instruction class: 00 ALU/shift, 01 lw, 10 sw, 11 branch
rs  input  5  source register
rt  input  5  second register
shamt  input  5  shift amount
func  input  4  function code
offset  input  16  immediate / branch offset
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  write address
imem_wdata  output  32  encoded instruction word
imem_ready  input  1  memory accepts the write this cycle
count  output  ADDR_W+1  words written in the current session
done  output  1  one-cycle pulse at session end
overflow  output  1  session ran out of memory before in_last; sticky until next start

Behaviour:
- Reset values: state IDLE; in_ready, imem_we, done, overflow = 0; imem_addr = BASE_ADDR; imem_wdata = 0; count = 0.
- Encoding layout: [31:30] opcode, [29:25] rs, [24:20] rt or shamt, [19:16] func, [15:0] offset.
- Canonical zeroing (unused fields forced to 0):
  - opcode 00: [24:20] = shamt if func[3]=1, else rt. offset kept only if func[2:1]=10, else 0.
  - opcode 01/10: rs, rt, func, offset used; shamt ignored.
  - opcode 11, func[3]=1: rs, rt, offset used.
  - opcode 11, func[3:1]=000: rs = rt = 0; offset used.
  - opcode 11, func[3:1]=001: rs = rt = offset = 0.
  - opcode 11, all other func: rs and offset used; rt = 0.
- FSM IDLE -> ACCEPT -> WRITE -> (ACCEPT | DONE) -> IDLE.
  - IDLE: in_ready = 0. On start, load imem_addr = BASE_ADDR, clear count and overflow, go to ACCEPT.
  - ACCEPT: in_ready = 1. On in_valid & in_ready, register the encoded word into imem_wdata, capture in_last, go to WRITE.
  - WRITE: imem_we = 1; imem_addr and imem_wdata held stable until imem_ready = 1. In the acknowledged cycle, count increments and imem_addr increments, unless it equals DEPTH-1.
    - If the captured last flag is set: go to DONE.
    - Else if imem_addr was DEPTH-1: set overflow, go to DONE.
    - Else: go to ACCEPT.
  - DONE: done = 1 for exactly one cycle, then IDLE.
- Latency: handshake cycle N gives imem_we high in cycle N+1. Best-case throughput is one word per 2 cycles.
- Boundaries:
  - start outside IDLE is ignored.
  - in_valid outside ACCEPT is ignored and not captured.
  - imem_addr never wraps.
  - in_last on address DEPTH-1 ends the session cleanly with overflow = 0.
  - Reset mid-WRITE drops imem_we asynchronously; the partial word is lost.

Optional Feature:
Macro INST_FIELD_CHECK_EN.
- When defined: adds output field_err (1 bit, reset 0). field_err is sticky for the session and is set when an accepted bundle carries a nonzero value in any field the canonical rules force to 0. Canonical zeroing still applies; the session is not stalled.
- When undefined: the port and its logic are absent, and nonzero unused fields are silently zeroed.

Test Plan:
- Reset, then start. Send opcode 00, rs 3, rt 5, func 0000, offset 0x1234, in_last=1, with imem_ready tied 1 -> one write of 0x06500000 at addr 0; count=1; done pulses once; overflow=0.
- Shift: opcode 00, rs 2, rt 7, shamt 4, func 1000 -> imem_wdata 0x04480000 (rt dropped). With INST_FIELD_CHECK_EN defined, field_err=1.
- Three-word session: sw (opcode 10, rs 1, rt 2, func 0001, offset 0x0010), then jump (opcode 11, func 0000, rs 4, offset 0x0040), then return (opcode 11, func 0010, rs 9, offset 0xFFFF, last). Hold imem_ready=0 for 3 cycles on the second write -> words 0x82210010, 0xC0000040, 0xC0020000 at addrs 0,1,2; addr/data stable while stalled; count=3.
- DEPTH=4 build: send 5 bundles without last -> 4 writes at addrs 0..3, overflow=1, done pulses, fifth bundle not accepted (in_ready=0 in IDLE).
- Assert rst_n low while in WRITE with imem_ready=0 -> imem_we drops immediately; all outputs at reset values. A new start restarts at BASE_ADDR.
- Pulse start while in ACCEPT, and in_valid while in IDLE -> no state change, no write, count unchanged.
